// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and word layout.
// Used by uart_rx today and by the planned uart_tx.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_WORD_W    = 9;
    localparam int FRAME_ERR_BIT  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input.
// The reset value matches the input's idle level so no false edge is seen after reset.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding a 9-bit FIFO write port with {frame_err, data}.
// Bits are sampled at their midpoint; RTS follows the FIFO almost-full flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx,
    output logic                   o_wr_en,
    output logic [UART_WORD_W-1:0] o_wr_data,
    input  logic                   i_fifo_full,
    input  logic                   i_fifo_almostfull,
    output logic                   o_rts_n,
    output logic                   o_overrun,
    input  logic                   i_clr_overrun,
    output logic                   o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    logic                      rx_s;
    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rx),
        .o_q   (rx_s)
    );

    // Start is confirmed at mid start bit, so every later sample lands mid-bit.
    // Setting overrun is written after the clear so a coinciding set wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            o_wr_en   <= 1'b0;
            o_wr_data <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            if (i_clr_overrun) begin
                o_overrun <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (!i_fifo_full) begin
                            o_wr_en                          <= 1'b1;
                            o_wr_data[FRAME_ERR_BIT]         <= ~rx_s;
                            o_wr_data[UART_DATA_BITS-1:0]    <= shreg;
                        end else begin
                            o_overrun <= 1'b1;
                        end
                        state <= rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rts_n <= 1'b1;
        end else begin
            o_rts_n <= i_fifo_almostfull;
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver, 8N1, LSB first; sits directly upstream of the receive FIFO (WIDTH=9).
- Oversamples the asynchronous RX line with a bit-period counter and samples each bit at its midpoint.
- Pushes one 9-bit word {frame_err, data[7:0]} per received frame into the FIFO write port.
- Drives RTS flow control from the FIFO almost-full flag; flags overrun when a frame arrives while the FIFO is full.

Parameters:
- CLKS_PER_BIT, 104, i_clk cycles per UART bit (12 MHz / 115200); must be >= 4.
- SYNC_STAGES, 2, flops in the RX input synchronizer; must be >= 2.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; synchronous, active-high.
- i_rx  input  1  asynchronous serial line; idle high.
- o_wr_en  output  1  one-cycle FIFO write strobe.
- o_wr_data  output  9  [8]=frame_err, [7:0]=received byte.
- i_fifo_full  input  1  FIFO full status.
- i_fifo_almostfull  input  1  FIFO almost-full status.
- o_rts_n  output  1  active-low ready-to-send toward the remote transmitter.
- o_overrun  output  1  sticky flag: a frame was dropped because the FIFO was full.
- i_clr_overrun  input  1  clears o_overrun.
- o_busy  output  1  high whenever state != IDLE.

Behaviour:
Reset values:
- o_wr_en=0, o_wr_data=0, o_rts_n=1, o_overrun=0, o_busy=0.
- state=IDLE, synchronizer flops=1, counters=0.

Synchronizer and counters:
- i_rx passes through SYNC_STAGES flops (reset 1) to give rx_s; all decisions use rx_s only.
- Bit counter width is $clog2(CLKS_PER_BIT); it wraps to 0 on each sample event.
- HALF = CLKS_PER_BIT/2 (integer division).

States:
- IDLE: on rx_s==0 -> START, cnt=0.
- START: when cnt==HALF-1, sample rx_s.
  - rx_s==0 -> DATA, cnt=0, bit_idx=0.
  - rx_s==1 -> IDLE (glitch rejected, no write).
- DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into shreg[bit_idx] (LSB first), cnt=0.
  - After bit_idx==7 -> STOP; otherwise bit_idx+1.
- STOP: when cnt==CLKS_PER_BIT-1, sample the stop bit; frame_err = ~rx_s. The word is emitted (see Output), then:
  - rx_s==1 -> IDLE (re-armed at mid stop bit).
  - rx_s==0 -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then -> IDLE. A break (line held low) therefore produces exactly one word 0x100.

Output:
- In the cycle after the stop sample, if i_fifo_full==0: o_wr_en=1 for exactly one cycle, o_wr_data={frame_err, shreg}.
- If i_fifo_full==1 at the stop sample: no write, and o_overrun is set in the cycle after the stop sample.
- o_wr_data holds its value between writes.

Overrun flag:
- o_overrun clears on i_clr_overrun.
- If set and clear coincide, set wins.

Flow control:
- o_rts_n is i_fifo_almostfull registered (1-cycle latency).
- A frame already in flight is always completed regardless of o_rts_n.

Latency:
- Falling edge on i_rx to the IDLE->START transition: SYNC_STAGES+1 cycles.
- Full-frame timing: the stop sample occurs HALF-1 + 9*CLKS_PER_BIT cycles after entering START.

Reset mid-frame:
- Abort immediately to IDLE and discard the partial byte.
- No o_wr_en pulse; o_overrun cleared.

Decomposition:
- Package uart_pkg:
  - typedef enum state_t {IDLE, START, DATA, STOP, WAIT_IDLE}.
  - localparams UART_DATA_BITS=8, UART_WORD_W=9, FRAME_ERR_BIT=8.
  - Shared by uart_rx and the future uart_tx.
- Sub-module sync_ff (parameter STAGES, RESET_VAL) for the input synchronizer; reused for other async inputs.

Test Plan (bench uses CLKS_PER_BIT=16):
- Send 0x55 with a valid stop bit -> exactly one o_wr_en, o_wr_data=0x055, o_overrun=0.
- Send 0xA3, then 0x0F back-to-back with zero idle between frames -> two writes, 0x0A3 then 0x00F, the second start detected on time.
- Send 0x3C with the stop bit driven low, then line high -> one write 0x13C (frame_err=1), then return to IDLE.
- Hold the line low for 30 bit times -> exactly one write 0x100 and state WAIT_IDLE; after the line goes high, a following 0x41 is received as 0x041.
- 4-cycle low glitch on an idle line -> START then IDLE, no write. Separately, hold i_fifo_full=1 during a 0x7E frame -> no write, o_overrun=1; pulse i_clr_overrun -> o_overrun=0.
- Assert i_rst during the 4th data bit of 0xFF -> no write, state IDLE next cycle. Toggle i_fifo_almostfull 0->1->0 -> o_rts_n follows 1 cycle later.
